// File: rtl/boot_rom_pkg.sv
// ============================================================================
// Module : boot_rom_pkg
// Brief  : Shared constants and FSM state type for the boot ROM bus slave.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package boot_rom_pkg;

   localparam int unsigned ROM_DEPTH     = 800;
   localparam int unsigned ROM_AW        = 10;
   localparam logic [31:0] BOOT_ROM_BASE = 32'h0000_8000;
   localparam logic [31:0] ERR_RDATA     = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RESP = 2'd1,
      ERR  = 2'd2
   } brom_state_e;

endpackage : boot_rom_pkg

`default_nettype wire

// File: rtl/boot_rom_addr_decode.sv
// ============================================================================
// Module : boot_rom_addr_decode
// Brief  : Combinational address check and word-index extraction for the ROM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_rom_addr_decode #(
   parameter logic [31:0] BASE_ADDR = boot_rom_pkg::BOOT_ROM_BASE,
   parameter int unsigned ROM_DEPTH = boot_rom_pkg::ROM_DEPTH,
   parameter int unsigned ROM_AW    = boot_rom_pkg::ROM_AW
) (
   input  logic [31:0]       addr_i,
   input  logic              we_i,
   input  logic              locked_i,
   output logic [ROM_AW-1:0] widx_o,
   output logic              ok_o
);

   logic [29:0] w_off_word;
   logic        w_above_base;
   logic        w_in_range;
   logic        w_aligned;

   // The ROM base is word aligned, so the word-granular subtraction equals
   // the byte offset shifted right by two.
   assign w_off_word   = addr_i[31:2] - BASE_ADDR[31:2];
   assign w_above_base = (addr_i >= BASE_ADDR);
   assign w_in_range   = ({2'b00, w_off_word} < ROM_DEPTH);
   assign w_aligned    = (addr_i[1:0] == 2'b00);

   assign widx_o = w_off_word[ROM_AW-1:0];
   assign ok_o   = ~we_i & w_aligned & w_above_base & w_in_range & ~locked_i;

endmodule : boot_rom_addr_decode

`default_nettype wire

// File: rtl/boot_rom_bus_if.sv
// ============================================================================
// Module : boot_rom_bus_if
// Brief  : req/gnt/rvalid bus slave driving the boot ROM macro CSN/A inputs.
//          Optional error counter enabled by macro BOOT_ROM_IF_ERR_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_rom_bus_if #(
   parameter logic [31:0] BASE_ADDR = boot_rom_pkg::BOOT_ROM_BASE,
   parameter int unsigned ROM_DEPTH = boot_rom_pkg::ROM_DEPTH,
   parameter int unsigned ROM_AW    = boot_rom_pkg::ROM_AW
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_i,
   output logic              gnt_o,
   input  logic [31:0]       addr_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [31:0]       wdata_i,
   output logic              rvalid_o,
   output logic [31:0]       rdata_o,
   output logic              err_o,
   input  logic              boot_lock_i,
   output logic              locked_o,
   output logic [15:0]       err_cnt_o,
   output logic              rom_csn_o,
   output logic [ROM_AW-1:0] rom_addr_o,
   input  logic [31:0]       rom_q_i
);

   import boot_rom_pkg::*;

   brom_state_e       r_state;
   brom_state_e       w_state_nxt;
   logic              r_locked;
   logic [ROM_AW-1:0] r_rom_addr;
   logic [ROM_AW-1:0] w_widx;
   logic              w_ok;
   logic              w_grant;
   logic              w_rom_sel;
   logic              w_unused_bus;

   // Read-only slave: byte enables and write data never reach the ROM.
   assign w_unused_bus = ^{be_i, wdata_i};

   boot_rom_addr_decode #(
      .BASE_ADDR (BASE_ADDR),
      .ROM_DEPTH (ROM_DEPTH),
      .ROM_AW    (ROM_AW)
   ) u_addr_decode (
      .addr_i   (addr_i),
      .we_i     (we_i),
      .locked_i (r_locked),
      .widx_o   (w_widx),
      .ok_o     (w_ok)
   );

   assign w_grant   = req_i & ~RST;
   assign gnt_o     = w_grant;
   assign w_rom_sel = w_grant & w_ok;
   assign rom_csn_o = ~w_rom_sel;
   // Address only moves on a real ROM access to avoid needless toggling.
   assign rom_addr_o = w_rom_sel ? w_widx : r_rom_addr;
   assign locked_o   = r_locked;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= IDLE;
         r_locked   <= 1'b0;
         r_rom_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_locked   <= r_locked | boot_lock_i;
         r_rom_addr <= rom_addr_o;
      end
   end

   always_comb begin
      w_state_nxt = IDLE;
      rvalid_o    = 1'b0;
      err_o       = 1'b0;
      rdata_o     = '0;
      if (w_grant) begin
         w_state_nxt = w_ok ? RESP : ERR;
      end
      case (r_state)
         RESP: begin
            rvalid_o = 1'b1;
            rdata_o  = rom_q_i;
         end
         ERR: begin
            rvalid_o = 1'b1;
            err_o    = 1'b1;
            rdata_o  = ERR_RDATA;
         end
         default: begin
         end
      endcase
   end

`ifdef BOOT_ROM_IF_ERR_CNT_EN
   logic [15:0] r_err_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_err_cnt <= '0;
      end else if ((r_state == ERR) && (r_err_cnt != 16'hFFFF)) begin
         r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign err_cnt_o = r_err_cnt;
`else
   assign err_cnt_o = 16'h0000;
`endif

endmodule : boot_rom_bus_if

`default_nettype wire

// File: tb/tb_boot_rom_bus_if.sv
// ============================================================================
// Module : tb_boot_rom_bus_if
// Brief  : Scoreboard bench for boot_rom_bus_if with a behavioural ROM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_rom_bus_if;

   localparam logic [31:0] BASE  = 32'h0000_8000;
   localparam int unsigned DEPTH = 800;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } resp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        req_i;
   logic        gnt_o;
   logic [31:0] addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        boot_lock_i;
   logic        locked_o;
   logic [15:0] err_cnt_o;
   logic        rom_csn_o;
   logic [9:0]  rom_addr_o;
   logic [31:0] rom_q = 32'h0;

   logic [31:0] rom_mem [0:1023];
   resp_t       sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        m_locked;
   logic [9:0]  m_rom_addr;
   int unsigned m_cnt;
   logic        m_inc;

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (!rom_csn_o) rom_q <= rom_mem[rom_addr_o];
   end

   boot_rom_bus_if dut (
      .CLK         (CLK),
      .RST         (RST),
      .req_i       (req_i),
      .gnt_o       (gnt_o),
      .addr_i      (addr_i),
      .we_i        (we_i),
      .be_i        (be_i),
      .wdata_i     (wdata_i),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .err_o       (err_o),
      .boot_lock_i (boot_lock_i),
      .locked_o    (locked_o),
      .err_cnt_o   (err_cnt_o),
      .rom_csn_o   (rom_csn_o),
      .rom_addr_o  (rom_addr_o),
      .rom_q_i     (rom_q)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One bus cycle: drive, check the grant-cycle outputs, then the response.
   task automatic cycle(input logic req, input logic [31:0] addr, input logic we,
                        input logic lock, input logic rst);
      logic       gnt;
      logic       ok;
      logic [9:0] idx;
      resp_t      r;
      req_i       = req;
      addr_i      = addr;
      we_i        = we;
      boot_lock_i = lock;
      RST         = rst;
      be_i        = 4'hF;
      wdata_i     = $urandom;
      gnt = req & ~rst;
      ok  = !we && (addr[1:0] == 2'b00) && (addr >= BASE) &&
            ((addr - BASE) < DEPTH * 4) && !m_locked;
      idx = 10'((addr - BASE) >> 2);
      @(negedge CLK);
      check("gnt", 32'(gnt_o), 32'(gnt));
      check("rom_csn", 32'(rom_csn_o), 32'(!(gnt && ok)));
      if (gnt && ok) m_rom_addr = idx;
      check("rom_addr", 32'(rom_addr_o), 32'(m_rom_addr));
      check("locked", 32'(locked_o), 32'(m_locked));
      if (gnt) begin
         r.err  = !ok;
         r.data = ok ? rom_mem[idx] : 32'h0;
         sb_q.push_back(r);
      end
      @(posedge CLK);
      #1;
      if (rst) begin
         m_locked   = 1'b0;
         m_rom_addr = '0;
         m_cnt      = 0;
      end else begin
         if (lock) m_locked = 1'b1;
         if (m_inc && m_cnt != 32'hFFFF) m_cnt++;
      end
      m_inc = 1'b0;
      if (sb_q.size() > 0) begin
         r = sb_q.pop_front();
         check("rvalid", 32'(rvalid_o), 32'd1);
         check("err", 32'(err_o), 32'(r.err));
         check("rdata", rdata_o, r.data);
         m_inc = r.err;
      end else begin
         check("rvalid_idle", 32'(rvalid_o), 32'd0);
         check("err_idle", 32'(err_o), 32'd0);
         check("rdata_idle", rdata_o, 32'd0);
      end
`ifdef BOOT_ROM_IF_ERR_CNT_EN
      check("err_cnt", 32'(err_cnt_o), m_cnt);
`else
      check("err_cnt_tied", 32'(err_cnt_o), 32'd0);
`endif
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0101);
      rom_mem[0]   = 32'h0000_0013;
      rom_mem[31]  = 32'h0100_006F;
      rom_mem[36]  = 32'h0000_0093;
      rom_mem[799] = 32'hDEAD_0799;

      RST = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0;
      boot_lock_i = 1'b0; be_i = '0; wdata_i = '0;
      repeat (2) @(posedge CLK);
      #1;
      m_locked = 1'b0; m_rom_addr = '0; m_cnt = 0; m_inc = 1'b0;

      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);        // reset values, req masked
      cycle(1'b1, 32'h8000, 1'b0, 1'b0, 1'b1);     // grant suppressed by RST
      cycle(1'b1, 32'h8000, 1'b0, 1'b0, 1'b0);     // word 0
      cycle(1'b1, 32'h807C, 1'b0, 1'b0, 1'b0);     // back-to-back reads
      cycle(1'b1, 32'h8090, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h8C7C, 1'b0, 1'b0, 1'b0);     // last valid word
      cycle(1'b1, 32'h8C80, 1'b0, 1'b0, 1'b0);     // word 800
      cycle(1'b1, 32'h7FFC, 1'b0, 1'b0, 1'b0);     // below base
      cycle(1'b1, 32'h8002, 1'b0, 1'b0, 1'b0);     // misaligned
      cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h8000, 1'b1, 1'b0, 1'b0);     // write rejected
      cycle(1'b0, 32'h8010, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, BASE + 32'($urandom_range(0, 899)) * 4, 1'b0, 1'b0, 1'b0);
      end
      cycle(1'b1, 32'h8004, 1'b0, 1'b1, 1'b0);     // read served during lock pulse
      cycle(1'b1, 32'h8000, 1'b0, 1'b0, 1'b0);     // now locked
      cycle(1'b0, 32'h8000, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 32'h8000, 1'b0, 1'b0, 1'b1);     // reset clears lock
      cycle(1'b1, 32'h8000, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h8000, 1'b0, 1'b0, 1'b1);     // grant with RST: no response
      cycle(1'b0, 32'h8000, 1'b0, 1'b0, 1'b0);
`ifdef BOOT_ROM_IF_ERR_CNT_EN
      for (int i = 0; i < 65540; i++) cycle(1'b1, 32'h8002, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h8C80, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 32'h8000, 1'b0, 1'b0, 1'b0);
      check("err_cnt_sat", 32'(err_cnt_o), 32'h0000_FFFF);
`endif
      cycle(1'b0, 32'h8000, 1'b0, 1'b0, 1'b0);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_boot_rom_bus_if

`default_nettype wire

// File: doc/boot_rom_bus_if.md
Name: boot_rom_bus_if

Overview:
Core-side bus slave that sits directly upstream of the boot ROM macro and is the only driver of the ROM's CSN/A inputs.
- Accepts core req/gnt/rvalid transactions in the instruction or data memory window.
- Decodes and checks each address, then drives the ROM select and word address.
- Returns the ROM's registered-address read data one cycle later.
- Rejects writes, misaligned or out-of-range accesses, and any access after boot lock, with an error response.

Parameters:
- BASE_ADDR, 32'h0000_8000: byte address of ROM word 0.
- ROM_DEPTH, 800: number of valid 32-bit ROM words.
- ROM_AW, 10: ROM word-address width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- req_i  in  1  core request.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  32  byte address.
- we_i  in  1  write enable; writes are always rejected.
- be_i  in  4  byte enables; ignored for reads.
- wdata_i  in  32  write data; ignored.
- rvalid_o  out  1  response valid, one cycle after grant.
- rdata_o  out  32  read data.
- err_o  out  1  error response, qualified by rvalid_o.
- boot_lock_i  in  1  pulse; permanently locks the ROM until reset.
- locked_o  out  1  sticky lock status.
- err_cnt_o  out  16  error count (optional feature).
- rom_csn_o  out  1  ROM chip select, active low.
- rom_addr_o  out  ROM_AW  ROM word address.
- rom_q_i  in  32  ROM data; valid the cycle after a cycle with rom_csn_o=0.

Behaviour:
- Clocking and reset:
  - One clock, CLK. Reset RST is synchronous and active-high.
  - Reset values: gnt_o=0 while RST=1, rvalid_o=0, err_o=0, rdata_o=0, locked_o=0, err_cnt_o=0, rom_csn_o=1, rom_addr_o=0, state=IDLE.
- Grant: gnt_o = req_i & ~RST. No wait states, one outstanding transaction, throughput one access per cycle (back-to-back grants allowed).
- Decode, combinational in the grant cycle N:
  - off = addr_i - BASE_ADDR, widx = off[ROM_AW+1:2].
  - ok = ~we_i & (addr_i[1:0]==0) & (addr_i >= BASE_ADDR) & (off[31:2] < ROM_DEPTH) & ~locked_o.
  - Comparisons are unsigned 32-bit; wrap of addr_i below BASE_ADDR is an error, not an alias.
- ROM drive in cycle N:
  - rom_csn_o = ~(req_i & ok).
  - rom_addr_o = widx when ok, else holds its previous registered value (no toggling on rejected or idle cycles).
- FSM (registered), states IDLE, RESP, ERR:
  - IDLE→RESP on grant & ok; IDLE→ERR on grant & ~ok.
  - From RESP or ERR: next state is chosen by the same rule if a new grant occurs, else IDLE.
- Outputs in cycle N+1:
  - RESP: rvalid_o=1, err_o=0, rdata_o=rom_q_i.
  - ERR: rvalid_o=1, err_o=1, rdata_o=32'h0.
  - IDLE: rvalid_o=0, rdata_o=0.
- Lock:
  - locked_o sets the cycle after boot_lock_i=1 and clears only on RST.
  - A grant in the same cycle as boot_lock_i is still served normally (the lock applies from the next cycle).
- Reset mid-operation: RST during a pending response drops it; rvalid_o=0 the following cycle and no late response is produced.

Optional Feature:
- Macro BOOT_ROM_IF_ERR_CNT_EN.
- Defined: err_cnt_o is a 16-bit counter that increments on each ERR response and saturates at 16'hFFFF; reset to 0.
- Undefined: err_cnt_o is tied to 16'h0 and no counter logic exists; port list is unchanged.

Decomposition:
- Package boot_rom_pkg: ROM_DEPTH, ROM_AW, BOOT_ROM_BASE, ERR_RDATA (32'h0), and the state enum brom_state_e {IDLE, RESP, ERR}.
- Sub-module boot_rom_addr_decode: purely combinational; inputs addr_i, we_i, locked; outputs widx and ok. Instantiated once.

Test Plan:
- Read word 0: req at 0x8000 → gnt same cycle; rvalid=1, err=0, rdata=32'h00000013 next cycle.
- Back-to-back reads: 0x807C then 0x8090 → rdata 32'h0100006F then 32'h00000093 on consecutive cycles, no gaps.
- Range and alignment: 0x8C80 (word 800), 0x7FFC, 0x8002 → each gives err=1, rdata=0, rom_csn_o held 1, rom_addr_o unchanged.
- Write: we_i=1 at 0x8000 → err=1, ROM not selected; with the macro defined, err_cnt_o increments by 1.
- Lock: pulse boot_lock_i, then read 0x8000 → err=1, locked_o=1; assert RST, read again → 32'h00000013.
- Reset mid-op: grant at 0x8000 with RST=1 in the same cycle → no rvalid in the next cycle; counter saturation check: 65536 errors → err_cnt_o stays 16'hFFFF.
